// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI between CP0 registers and the TLB array.
module tlb_op_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  input  logic             ex_flush,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  input  logic [IDX_W-1:0] cp0_index,
  output logic             s_req,
  output logic [18:0]      s_vpn2,
  output logic [7:0]       s_asid,
  input  logic             s_found,
  input  logic [IDX_W-1:0] s_index,
  output logic             r_req,
  output logic [IDX_W-1:0] r_index,
  input  logic [77:0]      r_entry,
  output logic             w_we,
  output logic [IDX_W-1:0] w_index,
  output logic [77:0]      w_entry,
  output logic             tlbp_we,
  output logic [31:0]      index_data,
  output logic             tlbr_we,
  output logic [31:0]      hi_data,
  output logic [31:0]      lo0_data,
  output logic [31:0]      lo1_data,
  output logic             op_done,
  output logic             op_err,
  output logic             refetch
);
  typedef enum logic [2:0] {IDLE, P_REQ, P_RSP, R_REQ, R_RSP, W_EXE, ERR} state_t;
  state_t           state;
  logic             armed;
  logic [26:0]      hi_q;
  logic [25:0]      lo0_q, lo1_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             unused_ok;
  assign unused_ok = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};
  // armed blocks acceptance in the first cycle after reset release
  assign accept = state == IDLE && armed && op_valid && !ex_flush;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      armed <= 1'b0;
      hi_q  <= '0;
      lo0_q <= '0;
      lo1_q <= '0;
      idx_q <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          hi_q  <= {cp0_entryhi[31:13], cp0_entryhi[7:0]};
          lo0_q <= cp0_entrylo0[25:0];
          lo1_q <= cp0_entrylo1[25:0];
          idx_q <= cp0_index;
          state <= op_type == 2'b01 ? P_REQ : op_type == 2'b10 ? R_REQ :
                   op_type == 2'b11 ? W_EXE : ERR;
        end
        P_REQ:   state <= ex_flush ? IDLE : P_RSP;
        R_REQ:   state <= ex_flush ? IDLE : R_RSP;
        default: state <= IDLE;
      endcase
    end
  end
  assign op_ready   = state == IDLE;
  assign s_req      = state == P_REQ && !ex_flush;
  assign s_vpn2     = hi_q[26:8];
  assign s_asid     = hi_q[7:0];
  assign r_req      = state == R_REQ && !ex_flush;
  assign r_index    = idx_q;
  assign w_we       = state == W_EXE;
  assign w_index    = idx_q;
  assign w_entry    = {hi_q, lo0_q[0] & lo1_q[0], lo0_q[25:1], lo1_q[25:1]};
  assign tlbp_we    = state == P_RSP;
  assign index_data = {~s_found, {(31-IDX_W){1'b0}}, s_index};
  assign tlbr_we    = state == R_RSP;
  assign hi_data    = {r_entry[77:59], 5'b0, r_entry[58:51]};
  assign lo0_data   = {6'b0, r_entry[49:25], r_entry[50]};
  assign lo1_data   = {6'b0, r_entry[24:0], r_entry[50]};
  assign op_done    = tlbp_we || tlbr_we || w_we || state == ERR;
  assign op_err     = state == ERR;
  assign refetch    = tlbr_we || w_we;
endmodule
